// File: rtl/mips5_pipeline_pkg.sv
// Shared encodings, ALU op set and pipeline register layouts for the five-stage MIPS subset core.
package mips5_pipeline_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_HALT = 6'b111111;

  localparam logic [XLEN-1:0] HALT_WORD = {26'b0, FN_HALT};
  localparam logic [XLEN-1:0] NOP_WORD  = '0;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor, AluSlt, AluSll, AluSrl, AluSra
  } alu_op_e;

  typedef struct packed {
    alu_op_e         alu_op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      shamt;
    logic [4:0]      dest;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            use_imm;
    logic            shift_var;
    logic            halt;
    logic [XLEN-1:0] imm;
  } ctrl_t;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      dest;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            halt;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0] wdata;
    logic [4:0]      dest;
    logic            reg_write;
  } mem_wb_t;

  // Unsupported encodings fall out with all-zero control, i.e. a bubble.
  function automatic ctrl_t decode(input logic [XLEN-1:0] instr);
    ctrl_t c;
    c       = '0;
    c.rs    = instr[25:21];
    c.rt    = instr[20:16];
    c.shamt = instr[10:6];
    case (instr[31:26])
      OP_RTYPE: begin
        c.dest      = instr[15:11];
        c.reg_write = 1'b1;
        case (instr[5:0])
          FN_ADDU: c.alu_op = AluAdd;
          FN_SUBU: c.alu_op = AluSub;
          FN_AND:  c.alu_op = AluAnd;
          FN_OR:   c.alu_op = AluOr;
          FN_XOR:  c.alu_op = AluXor;
          FN_NOR:  c.alu_op = AluNor;
          FN_SLT:  c.alu_op = AluSlt;
          FN_SLL:  c.alu_op = AluSll;
          FN_SRL:  c.alu_op = AluSrl;
          FN_SRA:  c.alu_op = AluSra;
          FN_SLLV: begin c.alu_op = AluSll; c.shift_var = 1'b1; end
          FN_SRLV: begin c.alu_op = AluSrl; c.shift_var = 1'b1; end
          FN_SRAV: begin c.alu_op = AluSra; c.shift_var = 1'b1; end
          default: c.reg_write = 1'b0;
        endcase
        c.halt = (instr == HALT_WORD);
      end
      OP_ADDI: begin
        c.dest = instr[20:16]; c.reg_write = 1'b1; c.use_imm = 1'b1;
        c.imm  = {{16{instr[15]}}, instr[15:0]};
      end
      OP_ANDI: begin
        c.dest = instr[20:16]; c.reg_write = 1'b1; c.use_imm = 1'b1; c.alu_op = AluAnd;
        c.imm  = {16'b0, instr[15:0]};
      end
      OP_ORI: begin
        c.dest = instr[20:16]; c.reg_write = 1'b1; c.use_imm = 1'b1; c.alu_op = AluOr;
        c.imm  = {16'b0, instr[15:0]};
      end
      OP_LW: begin
        c.dest = instr[20:16]; c.reg_write = 1'b1; c.mem_read = 1'b1; c.use_imm = 1'b1;
        c.imm  = {{16{instr[15]}}, instr[15:0]};
      end
      OP_SW: begin
        c.mem_write = 1'b1; c.use_imm = 1'b1;
        c.imm       = {{16{instr[15]}}, instr[15:0]};
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips5_pipeline_if.sv
// Controller-facing bus of the core: program load, run enable and debug read-back.
interface mips5_pipeline_if #(
  parameter int unsigned INST_SZ = 32,
  parameter int unsigned PC_SZ   = 32,
  parameter int unsigned REG_SZ  = 5
);
  logic               i_write;
  logic               i_enable;
  logic [INST_SZ-1:0] i_instruction;
  logic [REG_SZ-1:0]  i_debug_addr;
  logic [PC_SZ-1:0]   o_pc;
  logic [INST_SZ-1:0] o_mem;
  logic [INST_SZ-1:0] o_reg;
  logic               o_halt;

  modport master (
    output i_write, i_enable, i_instruction, i_debug_addr,
    input  o_pc, o_mem, o_reg, o_halt
  );

  modport slave (
    input  i_write, i_enable, i_instruction, i_debug_addr,
    output o_pc, o_mem, o_reg, o_halt
  );
endinterface

// File: rtl/mips5_alu.sv
// Combinational ALU; shifts act on b by shamt_i, which the caller selects (field or rs[4:0]).
module mips5_alu
  import mips5_pipeline_pkg::*;
(
  input  alu_op_e          op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [4:0]       shamt_i,
  output logic [XLEN-1:0]  result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      AluAdd:  result_o = a_i + b_i;
      AluSub:  result_o = a_i - b_i;
      AluAnd:  result_o = a_i & b_i;
      AluOr:   result_o = a_i | b_i;
      AluXor:  result_o = a_i ^ b_i;
      AluNor:  result_o = ~(a_i | b_i);
      AluSlt:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      AluSll:  result_o = b_i << shamt_i;
      AluSrl:  result_o = b_i >> shamt_i;
      AluSra:  result_o = $signed(b_i) >>> shamt_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/mips5_pipeline.sv
// Five-stage MIPS subset core with load-mode instruction fill, forwarding, load-use stall and HALT.
module mips5_pipeline
  import mips5_pipeline_pkg::*;
#(
  parameter int unsigned INST_SZ    = 32,
  parameter int unsigned PC_SZ      = 32,
  parameter int unsigned REG_SZ     = 5,
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 32
) (
  input logic            i_clk,
  input logic            i_reset,
  mips5_pipeline_if.slave bus
);

  localparam int unsigned IAW  = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW  = $clog2(DMEM_DEPTH);
  localparam int unsigned NREG = 2 ** REG_SZ;

  logic [PC_SZ-1:0]   pc_q, pc_d;
  logic               fetch_halted_q, fetch_halted_d;
  logic [IAW-1:0]     load_ptr_q;
  logic               halt_q;
  logic [INST_SZ-1:0] imem [IMEM_DEPTH];
  logic [INST_SZ-1:0] rf   [NREG];
  logic [INST_SZ-1:0] dmem [DMEM_DEPTH];

  logic [INST_SZ-1:0] if_id_q, fetch_word, fetch_instr;
  ctrl_t              id_ctrl;
  id_ex_t             id_ex_q, id_ex_d;
  ex_mem_t            ex_mem_q, ex_mem_d;
  mem_wb_t            mem_wb_q, mem_wb_d;

  logic               stall, wb_we;
  logic [INST_SZ-1:0] rs_val, rt_val, fwd_a, fwd_b, alu_b, alu_result;
  logic [4:0]         alu_shamt;
  logic [DAW-1:0]     mem_idx;

  // IF
  assign fetch_word  = imem[pc_q[IAW+1:2]];
  assign fetch_instr = fetch_halted_q ? NOP_WORD : fetch_word;

  always_comb begin
    pc_d           = pc_q;
    fetch_halted_d = fetch_halted_q;
    if (!stall && !fetch_halted_q) begin
      if (fetch_word == HALT_WORD) fetch_halted_d = 1'b1;
      else                         pc_d = pc_q + PC_SZ'(4);
    end
  end

  // ID: the load-use check compares raw rs/rt fields, whatever the consumer's format
  assign id_ctrl = decode(if_id_q);
  assign stall   = id_ex_q.ctrl.mem_read &&
                   ((id_ex_q.ctrl.rt == id_ctrl.rs) || (id_ex_q.ctrl.rt == id_ctrl.rt));
  assign wb_we   = mem_wb_q.reg_write && (mem_wb_q.dest != '0);

  always_comb begin
    rs_val = rf[id_ctrl.rs];
    rt_val = rf[id_ctrl.rt];
    if (wb_we && (mem_wb_q.dest == id_ctrl.rs)) rs_val = mem_wb_q.wdata;
    if (wb_we && (mem_wb_q.dest == id_ctrl.rt)) rt_val = mem_wb_q.wdata;
    id_ex_d = '0;
    if (!stall) begin
      id_ex_d.ctrl   = id_ctrl;
      id_ex_d.rs_val = rs_val;
      id_ex_d.rt_val = rt_val;
    end
  end

  // EX: EX/MEM forwarding is applied last so it wins over MEM/WB
  always_comb begin
    fwd_a = id_ex_q.rs_val;
    fwd_b = id_ex_q.rt_val;
    if (wb_we && (mem_wb_q.dest == id_ex_q.ctrl.rs)) fwd_a = mem_wb_q.wdata;
    if (wb_we && (mem_wb_q.dest == id_ex_q.ctrl.rt)) fwd_b = mem_wb_q.wdata;
    if (ex_mem_q.reg_write && (ex_mem_q.dest != '0)) begin
      if (ex_mem_q.dest == id_ex_q.ctrl.rs) fwd_a = ex_mem_q.result;
      if (ex_mem_q.dest == id_ex_q.ctrl.rt) fwd_b = ex_mem_q.result;
    end
    alu_b     = id_ex_q.ctrl.use_imm ? id_ex_q.ctrl.imm : fwd_b;
    alu_shamt = id_ex_q.ctrl.shift_var ? fwd_a[4:0] : id_ex_q.ctrl.shamt;
  end

  mips5_alu u_alu (
    .op_i     (id_ex_q.ctrl.alu_op),
    .a_i      (fwd_a),
    .b_i      (alu_b),
    .shamt_i  (alu_shamt),
    .result_o (alu_result)
  );

  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.result     = alu_result;
    ex_mem_d.store_data = fwd_b;
    ex_mem_d.dest       = id_ex_q.ctrl.dest;
    ex_mem_d.reg_write  = id_ex_q.ctrl.reg_write;
    ex_mem_d.mem_read   = id_ex_q.ctrl.mem_read;
    ex_mem_d.mem_write  = id_ex_q.ctrl.mem_write;
    ex_mem_d.halt       = id_ex_q.ctrl.halt;
  end

  // MEM
  assign mem_idx = ex_mem_q.result[DAW-1:0];

  always_comb begin
    mem_wb_d           = '0;
    mem_wb_d.wdata     = ex_mem_q.mem_read ? dmem[mem_idx] : ex_mem_q.result;
    mem_wb_d.dest      = ex_mem_q.dest;
    mem_wb_d.reg_write = ex_mem_q.reg_write;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_q           <= '0;
      fetch_halted_q <= 1'b0;
      load_ptr_q     <= '0;
      halt_q         <= 1'b0;
      if_id_q        <= '0;
      id_ex_q        <= '0;
      ex_mem_q       <= '0;
      mem_wb_q       <= '0;
    end else if (bus.i_enable) begin
      pc_q           <= pc_d;
      fetch_halted_q <= fetch_halted_d;
      if (!stall) if_id_q <= fetch_instr;
      id_ex_q        <= id_ex_d;
      ex_mem_q       <= ex_mem_d;
      mem_wb_q       <= mem_wb_d;
      if (ex_mem_q.halt) halt_q <= 1'b1;
    end else if (bus.i_write) begin
      load_ptr_q <= load_ptr_q + IAW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else if (bus.i_enable && wb_we) begin
      rf[mem_wb_q.dest] <= mem_wb_q.wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < int'(DMEM_DEPTH); i++) dmem[i] <= '0;
    end else if (bus.i_enable && ex_mem_q.mem_write) begin
      dmem[mem_idx] <= ex_mem_q.store_data;
    end
  end

  // Instruction memory keeps its contents across reset
  always_ff @(posedge i_clk) begin
    if (i_reset && !bus.i_enable && bus.i_write) imem[load_ptr_q] <= bus.i_instruction;
  end

  assign bus.o_pc   = pc_q;
  assign bus.o_halt = halt_q;
  assign bus.o_reg  = rf[bus.i_debug_addr];
  assign bus.o_mem  = dmem[bus.i_debug_addr[DAW-1:0]];

endmodule

// File: tb/tb_mips5_pipeline.sv
// Directed and random programs checked against an instruction-level reference interpreter.
module tb_mips5_pipeline;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips5_pipeline_if bus ();

  mips5_pipeline dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int plen;
  int halt_cycles;
  logic [31:0] prog  [64];
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [32];
  logic [31:0] m_pc;
  logic [31:0] v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic void set_reg(input logic [4:0] d, input logic [31:0] val);
    if (d != 5'd0) m_reg[d] = val;
  endfunction

  // Sequential ISA semantics; a correct pipeline must be indistinguishable from this.
  function automatic void model_exec(input logic [31:0] w);
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] a, b, se, ze, ea;
    rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sh = w[10:6];
    a  = m_reg[rs]; b = m_reg[rt];
    se = {{16{w[15]}}, w[15:0]};
    ze = {16'b0, w[15:0]};
    ea = a + se;
    case (w[31:26])
      6'd0: case (w[5:0])
        6'd33: set_reg(rd, a + b);
        6'd35: set_reg(rd, a - b);
        6'd36: set_reg(rd, a & b);
        6'd37: set_reg(rd, a | b);
        6'd38: set_reg(rd, a ^ b);
        6'd39: set_reg(rd, ~(a | b));
        6'd42: set_reg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        6'd0:  set_reg(rd, b << sh);
        6'd2:  set_reg(rd, b >> sh);
        6'd3:  set_reg(rd, $signed(b) >>> sh);
        6'd4:  set_reg(rd, b << a[4:0]);
        6'd6:  set_reg(rd, b >> a[4:0]);
        6'd7:  set_reg(rd, $signed(b) >>> a[4:0]);
        default: ;
      endcase
      6'd8:  set_reg(rt, ea);
      6'd12: set_reg(rt, a & ze);
      6'd13: set_reg(rt, a | ze);
      6'd35: set_reg(rt, m_mem[ea[4:0]]);
      6'd43: m_mem[ea[4:0]] = b;
      default: ;
    endcase
  endfunction

  task automatic model_run();
    int idx;
    for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_mem[i] = '0; end
    idx = 0;
    while (idx < plen && prog[idx] != 32'h0000_003F) begin
      model_exec(prog[idx]);
      idx++;
    end
    m_pc = 32'(idx * 4);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] r, off;
    logic [5:0]  fn;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7)); sh = 5'($urandom_range(0, 31));
    r  = $urandom;
    off = 32'($urandom_range(0, 16)) - 32'd8;
    case ($urandom_range(0, 7))
      0: begin
        case ($urandom_range(0, 6))
          0: fn = 6'd33; 1: fn = 6'd35; 2: fn = 6'd36; 3: fn = 6'd37;
          4: fn = 6'd38; 5: fn = 6'd39; default: fn = 6'd42;
        endcase
        return enc_r(rs, rt, rd, 5'd0, fn);
      end
      1: begin
        case ($urandom_range(0, 2)) 0: fn = 6'd0; 1: fn = 6'd2; default: fn = 6'd3; endcase
        return enc_r(5'd0, rt, rd, sh, fn);
      end
      2: begin
        case ($urandom_range(0, 2)) 0: fn = 6'd4; 1: fn = 6'd6; default: fn = 6'd7; endcase
        return enc_r(rs, rt, rd, 5'd0, fn);
      end
      3, 4: return enc_i(6'd8, rs, rt, r[15:0]);
      5: return enc_i(($urandom_range(0, 1) == 0) ? 6'd12 : 6'd13, rs, rt, r[15:0]);
      6: return enc_i(($urandom_range(0, 1) == 0) ? 6'd35 : 6'd43, rs, rt, off[15:0]);
      default: begin
        if ($urandom_range(0, 1) == 0) return enc_r(rs, rt, rd, 5'd0, 6'd8);
        return {6'b000010, r[25:0]};
      end
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_enable = 1'b0; bus.i_write = 1'b0;
    bus.i_instruction = '0; bus.i_debug_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_program();
    for (int i = 0; i < plen; i++) begin
      bus.i_instruction = prog[i];
      bus.i_write = 1'b1;
      @(negedge clk);
    end
    bus.i_write = 1'b0;
  endtask

  task automatic run_to_halt(input int pause_at, output int cyc);
    int          n;
    bit          done;
    logic [31:0] pc_hold;
    n = 0; done = 1'b0;
    bus.i_enable = 1'b1;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.o_halt) done = 1'b1;
      else if (n == pause_at) begin
        pc_hold = bus.o_pc;
        bus.i_enable = 1'b0;
        repeat (5) @(negedge clk);
        check("pause_pc", bus.o_pc, pc_hold);
        check("pause_halt", {31'b0, bus.o_halt}, 32'd0);
        bus.i_enable = 1'b1;
      end
    end
    bus.i_enable = 1'b0;
    cyc = n;
    check("halt_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pc"}, bus.o_pc, m_pc);
    for (int a = 0; a < 32; a++) begin
      bus.i_debug_addr = 5'(a);
      @(negedge clk);
      check($sformatf("%s_r%0d", tag, a), bus.o_reg, m_reg[a]);
      check($sformatf("%s_m%0d", tag, a), bus.o_mem, m_mem[a]);
    end
  endtask

  task automatic run_program(input string tag, input int pause_at);
    do_reset();
    load_program();
    model_run();
    run_to_halt(pause_at, halt_cycles);
    check_state(tag);
  endtask

  task automatic peek_reg(input int a, output logic [31:0] val);
    bus.i_debug_addr = 5'(a);
    @(negedge clk);
    val = bus.o_reg;
  endtask

  task automatic peek_mem(input int a, output logic [31:0] val);
    bus.i_debug_addr = 5'(a);
    @(negedge clk);
    val = bus.o_mem;
  endtask

  task automatic load_p1();
    plen = 3;
    prog[0] = enc_i(6'd8, 5'd0, 5'd2, 16'd2);
    prog[1] = enc_r(5'd0, 5'd2, 5'd10, 5'd0, 6'd33);
    prog[2] = 32'h0000_003F;
  endtask

  task automatic load_p3();
    plen = 6;
    prog[0] = enc_i(6'd8, 5'd0, 5'd1, 16'hFFF8);
    prog[1] = enc_r(5'd0, 5'd1, 5'd2, 5'd1, 6'd3);
    prog[2] = enc_r(5'd0, 5'd1, 5'd3, 5'd28, 6'd2);
    prog[3] = enc_r(5'd1, 5'd0, 5'd4, 5'd0, 6'd42);
    prog[4] = enc_r(5'd0, 5'd0, 5'd6, 5'd0, 6'd39);
    prog[5] = 32'h0000_003F;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_enable = 1'b0; bus.i_write = 1'b0;
    bus.i_instruction = '0; bus.i_debug_addr = '0;

    // Forwarding from EX/MEM; HALT at word 2 enters WB on enabled edge 2+4
    load_p1();
    run_program("p1", 0);
    check("p1_halt_edge", 32'(halt_cycles), 32'd6);
    peek_reg(2, v);  check("p1_r2", v, 32'd2);
    peek_reg(10, v); check("p1_r10", v, 32'd2);
    check("p1_pc", bus.o_pc, 32'd8);

    // Store, load, then load-use
    plen = 5;
    prog[0] = enc_i(6'd8, 5'd0, 5'd1, 16'd5);
    prog[1] = enc_i(6'd43, 5'd0, 5'd1, 16'd3);
    prog[2] = enc_i(6'd35, 5'd0, 5'd4, 16'd3);
    prog[3] = enc_r(5'd4, 5'd4, 5'd5, 5'd0, 6'd33);
    prog[4] = 32'h0000_003F;
    run_program("p2", 0);
    peek_mem(3, v); check("p2_m3", v, 32'd5);
    peek_reg(4, v); check("p2_r4", v, 32'd5);
    peek_reg(5, v); check("p2_r5", v, 32'd10);

    // Shifts and signed compare on a negative value
    load_p3();
    run_program("p3", 0);
    peek_reg(2, v); check("p3_r2", v, 32'hFFFF_FFFC);
    peek_reg(3, v); check("p3_r3", v, 32'h0000_000F);
    peek_reg(4, v); check("p3_r4", v, 32'd1);
    peek_reg(6, v); check("p3_r6", v, 32'hFFFF_FFFF);

    // r0 is hardwired
    plen = 2;
    prog[0] = enc_i(6'd8, 5'd0, 5'd0, 16'd7);
    prog[1] = 32'h0000_003F;
    run_program("p4", 0);
    peek_reg(0, v); check("p4_r0", v, 32'd0);

    // Pausing must not change results or the enabled-edge halt latency
    load_p1();
    run_program("p1_pause", 3);
    check("p1_pause_halt_edge", 32'(halt_cycles), 32'd6);
    load_p3();
    run_program("p3_pause", 4);
    peek_reg(2, v); check("p3_pause_r2", v, 32'hFFFF_FFFC);

    for (int t = 0; t < 10; t++) begin
      plen = $urandom_range(8, 30);
      for (int i = 0; i < plen - 1; i++) prog[i] = rand_instr();
      prog[plen-1] = 32'h0000_003F;
      run_program($sformatf("rnd%0d", t), (t % 2 == 1) ? $urandom_range(2, 10) : 0);
    end

    // Asynchronous reset after halt clears all architectural state
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("rst_halt", {31'b0, bus.o_halt}, 32'd0);
    check("rst_pc", bus.o_pc, 32'd0);
    for (int a = 0; a < 32; a++) begin
      bus.i_debug_addr = 5'(a);
      #1;
      check($sformatf("rst_r%0d", a), bus.o_reg, 32'd0);
      check($sformatf("rst_m%0d", a), bus.o_mem, 32'd0);
    end
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips5_pipeline.md
Name: mips5_pipeline

Overview:
- Five-stage (IF/ID/EX/MEM/WB) 32-bit MIPS-subset core with an instruction-load port and debug read ports.
- A controller preloads the program through i_instruction/i_write, then runs it with i_enable until the core raises o_halt.
- After halt, registers and data memory are inspected through i_debug_addr.

Parameters:
- INST_SZ, 32, instruction/data word width
- PC_SZ, 32, program counter width
- REG_SZ, 5, register/debug address width
- IMEM_DEPTH, 64, instruction memory words
- DMEM_DEPTH, 32, data memory words (word-addressed)

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  asynchronous reset, active-low
- i_write  in  1  load-mode strobe: store i_instruction into instruction memory
- i_enable  in  1  run enable; pipeline advances only when high
- i_instruction  in  32  instruction word to load
- i_debug_addr  in  5  debug index for o_reg and o_mem
- o_pc  out  32  current fetch PC (byte address)
- o_mem  out  32  data_mem[i_debug_addr], combinational
- o_reg  out  32  regfile[i_debug_addr], combinational
- o_halt  out  1  sticky high once HALT retires

Behaviour:
- Reset (i_reset=0, asynchronous) clears all of the following to 0:
  - PC, load pointer, all pipeline registers (bubbles), regfile, data memory, o_halt.
  - Instruction memory is not cleared. Unwritten words read 0, which decodes as NOP.
- Load mode (i_enable=0, i_write=1):
  - Each rising edge writes i_instruction to imem[load_ptr], then load_ptr increments.
  - The pointer wraps at IMEM_DEPTH.
  - i_write is ignored while i_enable=1.
- i_enable=0: PC, pipeline, regfile and dmem hold. Debug outputs stay live.
- Fetch:
  - instr = imem[PC[7:2]]; PC += 4 each enabled cycle.
  - If the fetched word is HALT (0x0000003F), the PC freezes at the HALT address and all subsequent fetches inject NOPs.
- Supported instructions; any other encoding executes as NOP:
  - R-type ALU: ADDU, SUBU, AND, OR, XOR, NOR, SLT (signed).
  - R-type shifts: SLL, SRL, SRA (by shamt) and SLLV, SRLV, SRAV (by rs[4:0]).
  - I-type: ADDI (sign-extended immediate, no overflow trap), ANDI, ORI (zero-extended immediate).
  - LW, SW with effective address = rs + sext(offset), used as a word index modulo DMEM_DEPTH.
- Register file:
  - r0 always reads 0 and writes to it are discarded.
  - Write occurs in WB; a same-cycle read of the written register returns the new value (write-through).
- Forwarding:
  - EX operands are forwarded from EX/MEM (priority) and MEM/WB when the destination matches rs/rt and is nonzero.
- Load-use hazard:
  - When the instruction in EX is LW and its rt equals the ID instruction's rs or rt, stall IF/ID for 1 cycle and insert a bubble in EX.
- HALT handling:
  - HALT propagates as a marker through the stages.
  - o_halt rises on the edge where HALT enters WB: 4 enabled edges after it is fetched. All older instructions have been written back by then.
  - o_halt stays high until reset.
- Mid-run reset returns the core to load state. The program must be reloaded unless instruction memory retention is desired; memory is retained.

Decomposition:
- Shared package holds:
  - opcode/funct constants: ADDU 100001, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111, HALT 111111.
  - opcodes ADDI 001000, ANDI 001100, ORI 001101, LW 100011, SW 101011.
  - the ALU operation enum.
- One natural sub-module: mips5_alu (combinational, operands plus op select -> result).

Test Plan:
- Load ADDI r2,r0,2; ADDU r10,r0,r2; HALT, then enable -> o_halt rises; o_reg r2=2, r10=2 (EX/MEM forwarding); o_pc=8.
- ADDI r1,r0,5; SW r1,3(r0); LW r4,3(r0); ADDU r5,r4,r4; HALT -> o_mem[3]=5, r4=5, r5=10 (load-use stall).
- ADDI r1,r0,-8; SRA r2,r1,1; SRL r3,r1,28; SLT r4,r1,r0; NOR r6,r0,r0; HALT -> r2=0xFFFFFFFC, r3=0xF, r4=1, r6=0xFFFFFFFF.
- ADDI r0,r0,7; HALT -> r0 reads 0.
- Run with i_enable deasserted mid-program for 5 cycles -> PC and registers hold; final results identical to an uninterrupted run.
- Assert i_reset low after halt -> o_halt=0, o_pc=0, all o_reg=0, all o_mem=0.
